// File: rtl/screen_power_ctrl.sv
// Display power sequencer: OFF -> WAKE (init handshake) -> ACTIVE -> DIM -> OFF on idle.
// Optional init-ack timeout in WAKE is enabled by defining SCREEN_INIT_TIMEOUT_EN.
module screen_power_ctrl #(
   parameter int unsigned CT_W        = 23,
   parameter int unsigned DIM_CYCLES  = 4_000_000,
   parameter int unsigned OFF_CYCLES  = 8_000_000,
   parameter int unsigned WAKE_CYCLES = 1_000_000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            key_evt,
   input  logic            hold,
   input  logic            force_off,
   input  logic            init_ack,
   output logic            init_req,
   output logic            screen_on,
   output logic            dim,
   output logic [1:0]      state,
   output logic [CT_W-1:0] idle_ct,
   output logic            init_err
);

   typedef enum logic [1:0] {
      StOff    = 2'd0,
      StWake   = 2'd1,
      StActive = 2'd2,
      StDim    = 2'd3
   } state_e;

   localparam logic [CT_W-1:0] DIM_CT = CT_W'(DIM_CYCLES);
   localparam logic [CT_W-1:0] OFF_CT = CT_W'(OFF_CYCLES);

   state_e          st_q, st_d;
   logic [CT_W-1:0] ct_d;
   logic [CT_W-1:0] ct_inc;
   logic            err_d;
   logic            err_q;
   logic            act;

   assign act    = key_evt | hold;
   assign ct_inc = (idle_ct == {CT_W{1'b1}}) ? idle_ct : idle_ct + 1'b1;
   assign state  = st_q;

   always_comb begin
      st_d  = st_q;
      ct_d  = idle_ct;
      err_d = 1'b0;
      if (force_off) begin
         st_d = StOff;
         ct_d = '0;
      end else begin
         unique case (st_q)
            StOff: begin
               ct_d = '0;
               if (act) st_d = StWake;
            end
            StWake: begin
               if (init_ack) begin
                  st_d = StActive;
                  ct_d = '0;
               end
`ifdef SCREEN_INIT_TIMEOUT_EN
               else if (ct_inc == CT_W'(WAKE_CYCLES)) begin
                  st_d  = StOff;
                  ct_d  = '0;
                  err_d = 1'b1;
               end
`endif
               else begin
                  ct_d = ct_inc;
               end
            end
            StActive: begin
               if (act) begin
                  ct_d = '0;
               end else begin
                  ct_d = ct_inc;
                  if (ct_inc == DIM_CT) st_d = StDim;
               end
            end
            StDim: begin
               if (act) begin
                  st_d = StActive;
                  ct_d = '0;
               end else if (ct_inc == OFF_CT) begin
                  st_d = StOff;
                  ct_d = '0;
               end else begin
                  ct_d = ct_inc;
               end
            end
            default: begin
               st_d = StOff;
               ct_d = '0;
            end
         endcase
      end
   end

   // Output flags are registered from the next state so they line up with st_q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q      <= StOff;
         idle_ct   <= '0;
         init_req  <= 1'b0;
         screen_on <= 1'b0;
         dim       <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         st_q      <= st_d;
         idle_ct   <= ct_d;
         init_req  <= (st_d == StWake);
         screen_on <= (st_d == StActive) || (st_d == StDim);
         dim       <= (st_d == StDim);
         err_q     <= err_d;
      end
   end

`ifdef SCREEN_INIT_TIMEOUT_EN
   assign init_err = err_q;
`else
   logic unused_cfg;
   assign unused_cfg = ^{WAKE_CYCLES, err_q};
   assign init_err   = 1'b0;
`endif

endmodule

// File: tb/tb_screen_power_ctrl.sv
// Directed self-checking bench for screen_power_ctrl (DIM=4, OFF=8, WAKE=3, 8-bit counter).
module tb_screen_power_ctrl;

   localparam int unsigned CT_W = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            key_evt, hold, force_off, init_ack;
   logic            init_req, screen_on, dim, init_err;
   logic [1:0]      state;
   logic [CT_W-1:0] idle_ct;

   int checks   = 0;
   int failures = 0;

   screen_power_ctrl #(
      .CT_W        (CT_W),
      .DIM_CYCLES  (4),
      .OFF_CYCLES  (8),
      .WAKE_CYCLES (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_evt   (key_evt),
      .hold      (hold),
      .force_off (force_off),
      .init_ack  (init_ack),
      .init_req  (init_req),
      .screen_on (screen_on),
      .dim       (dim),
      .state     (state),
      .idle_ct   (idle_ct),
      .init_err  (init_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic err_seen;
      rst = 1'b1; key_evt = 1'b0; hold = 1'b0; force_off = 1'b0; init_ack = 1'b0;
      #12;
      check("rst_state", 32'(state), 0);
      check("rst_ct", 32'(idle_ct), 0);
      check("rst_req", 32'(init_req), 0);
      check("rst_on", 32'(screen_on), 0);
      check("rst_dim", 32'(dim), 0);
      check("rst_err", 32'(init_err), 0);
      rst = 1'b0;
      tick();

      // Wake: key pulse, ack two cycles later
      key_evt = 1'b1; tick(); key_evt = 1'b0;
      check("wake1_state", 32'(state), 1);
      check("wake1_req", 32'(init_req), 1);
      tick();
      check("wake2_state", 32'(state), 1);
      check("wake2_ct", 32'(idle_ct), 1);
      init_ack = 1'b1; tick(); init_ack = 1'b0;
      check("act_state", 32'(state), 2);
      check("act_req", 32'(init_req), 0);
      check("act_on", 32'(screen_on), 1);
      check("act_ct", 32'(idle_ct), 0);

      // Idle run down to DIM then OFF
      for (int k = 1; k <= 7; k++) begin
         tick();
         check("idle_ct", 32'(idle_ct), 32'(k));
         check("idle_state", 32'(state), (k >= 4) ? 3 : 2);
         check("idle_dim", 32'(dim), (k >= 4) ? 1 : 0);
      end
      tick();
      check("off_state", 32'(state), 0);
      check("off_ct", 32'(idle_ct), 0);
      check("off_on", 32'(screen_on), 0);
      check("off_dim", 32'(dim), 0);

      // Re-wake, then reactivate from DIM at idle_ct=6
      key_evt = 1'b1; tick(); key_evt = 1'b0;
      init_ack = 1'b1; tick(); init_ack = 1'b0;
      check("rewake_state", 32'(state), 2);
      for (int k = 0; k < 6; k++) tick();
      check("dim6_state", 32'(state), 3);
      check("dim6_ct", 32'(idle_ct), 6);
      key_evt = 1'b1; tick(); key_evt = 1'b0;
      check("react_state", 32'(state), 2);
      check("react_dim", 32'(dim), 0);
      check("react_ct", 32'(idle_ct), 0);
      hold = 1'b1;
      for (int k = 0; k < 20; k++) tick();
      hold = 1'b0;
      check("hold_state", 32'(state), 2);
      check("hold_ct", 32'(idle_ct), 0);

      // Override with simultaneous activity / ack
      force_off = 1'b1; key_evt = 1'b1; tick(); key_evt = 1'b0;
      check("fo_act_state", 32'(state), 0);
      check("fo_act_ct", 32'(idle_ct), 0);
      key_evt = 1'b1; tick(); key_evt = 1'b0;
      check("fo_hold_state", 32'(state), 0);
      force_off = 1'b0;
      key_evt = 1'b1; tick(); key_evt = 1'b0;
      check("fo_wake_state", 32'(state), 1);
      force_off = 1'b1; init_ack = 1'b1; tick(); force_off = 1'b0; init_ack = 1'b0;
      check("fo_wake_off", 32'(state), 0);
      check("fo_wake_req", 32'(init_req), 0);
      init_ack = 1'b1; tick(); init_ack = 1'b0;
      check("ack_in_off", 32'(state), 0);

`ifdef SCREEN_INIT_TIMEOUT_EN
      key_evt = 1'b1; tick(); key_evt = 1'b0;
      tick(); tick();
      check("to_wake_state", 32'(state), 1);
      check("to_wake_err", 32'(init_err), 0);
      tick();
      check("to_off_state", 32'(state), 0);
      check("to_err_pulse", 32'(init_err), 1);
      check("to_off_req", 32'(init_req), 0);
      tick();
      check("to_err_clear", 32'(init_err), 0);
      key_evt = 1'b1; tick(); key_evt = 1'b0;
      tick(); tick();
      init_ack = 1'b1; tick(); init_ack = 1'b0;
      check("to_ack_state", 32'(state), 2);
      check("to_ack_err", 32'(init_err), 0);
`else
      key_evt = 1'b1; tick(); key_evt = 1'b0;
      err_seen = 1'b0;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (init_err !== 1'b0) err_seen = 1'b1;
      end
      check("nto_state", 32'(state), 1);
      check("nto_err", 32'(err_seen), 0);
      check("nto_sat_ct", 32'(idle_ct), 255);
`endif

      // Async reset between edges while in WAKE
      force_off = 1'b1; tick(); force_off = 1'b0;
      key_evt = 1'b1; tick(); key_evt = 1'b0;
      check("ar_pre_state", 32'(state), 1);
      check("ar_pre_req", 32'(init_req), 1);
      #2 rst = 1'b1;
      #1;
      check("ar_state", 32'(state), 0);
      check("ar_req", 32'(init_req), 0);
      check("ar_ct", 32'(idle_ct), 0);
      check("ar_on", 32'(screen_on), 0);
      rst = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
